// File: rtl/local_max_tree_tx.sv
// local_max_tree_tx: signed max tree over a 64x16b chunk, per-mode local max select, group framing.
// Latency: 3 enabled cycles from acceptance to output (4 when MAXTREE_IN_REG_EN is defined).
// Backpressure: o_ready mirrors i_en; i_en=0 freezes every register so nothing is dropped.
module local_max_tree_tx #(
    parameter int DW    = 16,
    parameter int NELEM = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [3:0]            i_length_mode,
    input  logic [DW*NELEM-1:0]   i_in_flat,
    input  logic                  i_clr_err,
    output logic                  o_valid_max,
    output logic [DW-1:0]         o_loc_max,
    output logic [3:0]            o_length_mode,
    output logic [DW*NELEM-1:0]   o_in_flat,
    output logic [DW-1:0]         o_max64_0,
    output logic [DW-1:0]         o_max32_0,
    output logic [DW-1:0]         o_max32_1,
    output logic [DW-1:0]         o_max16_0,
    output logic [DW-1:0]         o_max16_1,
    output logic [DW-1:0]         o_max16_2,
    output logic [DW-1:0]         o_max16_3,
    output logic                  o_group_last,
    output logic                  o_err_proto
);
    localparam int FW  = DW * NELEM;
    localparam int N4  = NELEM / 4;
    localparam int N16 = NELEM / 16;
    localparam logic [DW-1:0] NEG_MIN = {1'b1, {(DW-1){1'b0}}};

    typedef enum logic {ST_IDLE, ST_IN_GRP} state_t;

    // Signed strict greater-than; on a tie the lower-index operand a is kept.
    function automatic logic [DW-1:0] f_max(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return ($signed(b) > $signed(a)) ? b : a;
    endfunction

    logic          w_f_vld;
    logic [3:0]    w_f_mode;
    logic [FW-1:0] w_f_flat;

    assign o_ready = i_en;

`ifdef MAXTREE_IN_REG_EN
    logic          r_in_vld;
    logic [3:0]    r_in_mode;
    logic [FW-1:0] r_in_flat;

    // Optional input register; framing is evaluated on its outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_in_vld  <= 1'b0;
            r_in_mode <= '0;
            r_in_flat <= '0;
        end else if (i_en) begin
            r_in_vld  <= i_valid;
            r_in_mode <= i_length_mode;
            r_in_flat <= i_in_flat;
        end
    end
    assign w_f_vld  = r_in_vld;
    assign w_f_mode = r_in_mode;
    assign w_f_flat = r_in_flat;
`else
    assign w_f_vld  = i_valid;
    assign w_f_mode = i_length_mode;
    assign w_f_flat = i_in_flat;
`endif

    // ---------------- framing FSM ----------------
    state_t     r_state, w_state_nxt;
    logic [3:0] r_cnt, w_cnt_nxt, r_tgt, w_tgt_nxt, r_mode, w_mode_nxt;
    logic       w_acc, w_last, w_err_set, r_err;

    assign w_acc = w_f_vld & i_en;

    // Framing state, counter, group target and latched mode.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_tgt   <= '0;
            r_mode  <= '0;
        end else if (i_en) begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tgt   <= w_tgt_nxt;
            r_mode  <= w_mode_nxt;
        end
    end

    // Next framing state; a mode change or a gap inside a group abandons it and flags an error.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_tgt_nxt   = r_tgt;
        w_mode_nxt  = r_mode;
        w_last      = 1'b0;
        w_err_set   = 1'b0;
        if (w_acc) begin
            w_err_set = (w_f_mode >= 4'd14);
            if (r_state == ST_IN_GRP && w_f_mode == r_mode) begin
                if (r_cnt + 4'd1 == r_tgt) begin
                    w_last      = 1'b1;
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end else begin
                if (r_state == ST_IN_GRP) begin
                    w_err_set = 1'b1;
                end
                if (w_f_mode >= 4'd3 && w_f_mode <= 4'd13) begin
                    w_state_nxt = ST_IN_GRP;
                    w_cnt_nxt   = 4'd1;
                    w_tgt_nxt   = w_f_mode - 4'd1;
                    w_mode_nxt  = w_f_mode;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_last      = 1'b1;
                end
            end
        end else if (i_en && r_state == ST_IN_GRP) begin
            w_err_set   = 1'b1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end
    end

    // Sticky protocol error; a same-cycle clear wins over a new error.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)       r_err <= 1'b0;
        else if (i_en) begin
            if (i_clr_err)      r_err <= 1'b0;
            else if (w_err_set) r_err <= 1'b1;
        end
    end
    assign o_err_proto = r_err;

    // ---------------- compare tree ----------------
    logic [DW-1:0] w_m4 [N4];
    logic [DW-1:0] w_m16 [N16];
    logic [DW-1:0] r_s1_m4 [N4];
    logic [DW-1:0] r_s2_m16 [N16];
    logic          r_s1_vld, r_s1_last, r_s2_vld, r_s2_last;
    logic [3:0]    r_s1_mode, r_s2_mode;
    logic [FW-1:0] r_s1_flat, r_s2_flat;
    logic [DW-1:0] w_m32_0, w_m32_1, w_m64, w_loc;

    // S1 and S2 reduction: groups of four over two compare levels each.
    always_comb begin
        for (int g = 0; g < N4; g++) begin
            w_m4[g] = f_max(f_max(w_f_flat[DW*(4*g)   +: DW], w_f_flat[DW*(4*g+1) +: DW]),
                            f_max(w_f_flat[DW*(4*g+2) +: DW], w_f_flat[DW*(4*g+3) +: DW]));
        end
        for (int q = 0; q < N16; q++) begin
            w_m16[q] = f_max(f_max(r_s1_m4[4*q],   r_s1_m4[4*q+1]),
                             f_max(r_s1_m4[4*q+2], r_s1_m4[4*q+3]));
        end
    end

    // S3 reduction and local max select; illegal modes 14/15 fall into the full-row case.
    always_comb begin
        w_m32_0 = f_max(r_s2_m16[0], r_s2_m16[1]);
        w_m32_1 = f_max(r_s2_m16[2], r_s2_m16[3]);
        w_m64   = f_max(w_m32_0, w_m32_1);
        case (r_s2_mode)
            4'd0:    w_loc = r_s2_m16[0];
            4'd1:    w_loc = w_m32_0;
            default: w_loc = w_m64;
        endcase
    end

    // Pipeline registers S1..S3; group_last and data travel with their beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int g = 0; g < N4; g++)  r_s1_m4[g]  <= NEG_MIN;
            for (int q = 0; q < N16; q++) r_s2_m16[q] <= NEG_MIN;
            {r_s1_vld, r_s1_last, r_s2_vld, r_s2_last} <= '0;
            {r_s1_mode, r_s2_mode} <= '0;
            {r_s1_flat, r_s2_flat} <= '0;
            o_valid_max   <= 1'b0;
            o_group_last  <= 1'b0;
            o_length_mode <= '0;
            o_in_flat     <= '0;
            o_loc_max     <= NEG_MIN;
            o_max64_0     <= NEG_MIN;
            o_max32_0     <= NEG_MIN;
            o_max32_1     <= NEG_MIN;
            o_max16_0     <= NEG_MIN;
            o_max16_1     <= NEG_MIN;
            o_max16_2     <= NEG_MIN;
            o_max16_3     <= NEG_MIN;
        end else if (i_en) begin
            r_s1_m4   <= w_m4;
            r_s1_vld  <= w_f_vld;
            r_s1_last <= w_last;
            r_s1_mode <= w_f_mode;
            r_s1_flat <= w_f_flat;
            r_s2_m16  <= w_m16;
            r_s2_vld  <= r_s1_vld;
            r_s2_last <= r_s1_last;
            r_s2_mode <= r_s1_mode;
            r_s2_flat <= r_s1_flat;
            o_valid_max   <= r_s2_vld;
            o_group_last  <= r_s2_last;
            o_length_mode <= r_s2_mode;
            o_in_flat     <= r_s2_flat;
            o_loc_max     <= w_loc;
            o_max64_0     <= w_m64;
            o_max32_0     <= w_m32_0;
            o_max32_1     <= w_m32_1;
            o_max16_0     <= r_s2_m16[0];
            o_max16_1     <= r_s2_m16[1];
            o_max16_2     <= r_s2_m16[2];
            o_max16_3     <= r_s2_m16[3];
        end
    end
endmodule

// File: tb/tb_local_max_tree_tx.sv
`timescale 1ns/1ps
// Bench for local_max_tree_tx: table of chunk vectors plus directed framing/stall/reset sequences.
// Expected results are queued when a beat is accepted and compared when the DUT emits it.
// Error flag and freeze behaviour are checked directly after the relevant cycles.
module tb_local_max_tree_tx;
    localparam int FW = 1024;
`ifdef MAXTREE_IN_REG_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic i_rst_n, i_en, i_valid, o_ready, i_clr_err;
    logic [3:0] i_length_mode, o_length_mode;
    logic [FW-1:0] i_in_flat, o_in_flat;
    logic o_valid_max, o_group_last, o_err_proto;
    logic [15:0] o_loc_max, o_max64_0, o_max32_0, o_max32_1;
    logic [15:0] o_max16_0, o_max16_1, o_max16_2, o_max16_3;

    local_max_tree_tx dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en), .i_valid(i_valid), .o_ready(o_ready),
        .i_length_mode(i_length_mode), .i_in_flat(i_in_flat), .i_clr_err(i_clr_err),
        .o_valid_max(o_valid_max), .o_loc_max(o_loc_max), .o_length_mode(o_length_mode),
        .o_in_flat(o_in_flat), .o_max64_0(o_max64_0), .o_max32_0(o_max32_0),
        .o_max32_1(o_max32_1), .o_max16_0(o_max16_0), .o_max16_1(o_max16_1),
        .o_max16_2(o_max16_2), .o_max16_3(o_max16_3), .o_group_last(o_group_last),
        .o_err_proto(o_err_proto)
    );

    typedef struct {
        logic [3:0]    mode;
        logic [FW-1:0] flat;
        logic          last;
        logic [15:0]   loc, m64, m32_0, m32_1, m16_0, m16_1, m16_2, m16_3;
    } exp_t;

    typedef struct {
        logic [3:0]    mode;
        logic [FW-1:0] flat;
        logic          last;
        logic [15:0]   loc;
        logic [15:0]   m64;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sbq[$];
    vec_t tbl[12];

    function automatic logic [FW-1:0] fill(input logic [15:0] v);
        logic [FW-1:0] f;
        for (int k = 0; k < 64; k++) f[16*k +: 16] = v;
        return f;
    endfunction

    function automatic logic [FW-1:0] put(input logic [FW-1:0] f, input int k, input logic [15:0] v);
        logic [FW-1:0] r;
        r = f;
        r[16*k +: 16] = v;
        return r;
    endfunction

    function automatic logic [15:0] rmax(input logic [FW-1:0] f, input int lo, input int hi);
        logic signed [15:0] b, e;
        b = f[16*lo +: 16];
        for (int k = lo + 1; k <= hi; k++) begin
            e = f[16*k +: 16];
            if (e > b) b = e;
        end
        return b;
    endfunction

    function automatic exp_t mk(input logic [3:0] mode, input logic [FW-1:0] flat, input logic last);
        exp_t e;
        e.mode  = mode;
        e.flat  = flat;
        e.last  = last;
        e.m16_0 = rmax(flat, 0, 15);
        e.m16_1 = rmax(flat, 16, 31);
        e.m16_2 = rmax(flat, 32, 47);
        e.m16_3 = rmax(flat, 48, 63);
        e.m32_0 = rmax(flat, 0, 31);
        e.m32_1 = rmax(flat, 32, 63);
        e.m64   = rmax(flat, 0, 63);
        e.loc   = (mode == 4'd0) ? e.m16_0 : (mode == 4'd1) ? e.m32_0 : e.m64;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock; outputs sampled 1ns after the edge and scored if that edge advanced the pipe.
    task automatic tick();
        logic en_s;
        exp_t e;
        en_s = i_en;
        @(posedge i_clk);
        #1;
        if (en_s && o_valid_max) begin
            if (sbq.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("loc_max", o_loc_max, e.loc);
                chk("max64", o_max64_0, e.m64);
                chk("max32_0", o_max32_0, e.m32_0);
                chk("max32_1", o_max32_1, e.m32_1);
                chk("max16_0", o_max16_0, e.m16_0);
                chk("max16_1", o_max16_1, e.m16_1);
                chk("max16_2", o_max16_2, e.m16_2);
                chk("max16_3", o_max16_3, e.m16_3);
                chk("group_last", o_group_last, e.last);
                chk("mode_out", o_length_mode, e.mode);
                chk("flat_match", o_in_flat === e.flat, 1);
            end
        end
    endtask

    task automatic drive(input exp_t e);
        i_valid       = 1'b1;
        i_length_mode = e.mode;
        i_in_flat     = e.flat;
        if (i_en) sbq.push_back(e);
        tick();
    endtask

    task automatic flush();
        i_valid = 1'b0;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) tick();
        chk("flush_empty", sbq.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [FW-1:0] f;
        logic [15:0]   snap_loc;
        logic [FW-1:0] snap_flat;
        logic          snap_vld;
        exp_t          e;

        tbl[0]  = '{4'd2, fill(16'h8000), 1'b1, 16'h8000, 16'h8000};
        tbl[1]  = '{4'd2, put(put(fill(16'hffff), 5, 16'd7), 9, 16'd7), 1'b1, 16'd7, 16'd7};
        tbl[2]  = '{4'd5, put(fill(16'hffce), 40, 16'd3), 1'b0, 16'd3, 16'd3};
        tbl[3]  = '{4'd5, put(fill(16'hffce), 2, 16'd10), 1'b0, 16'd10, 16'd10};
        tbl[4]  = '{4'd5, put(fill(16'hffce), 63, 16'hfffe), 1'b0, 16'hfffe, 16'hfffe};
        tbl[5]  = '{4'd5, put(fill(16'hffce), 20, 16'd4), 1'b1, 16'd4, 16'd4};
        tbl[6]  = '{4'd5, put(fill(16'hff00), 10, 16'd8), 1'b0, 16'd8, 16'd8};
        tbl[7]  = '{4'd5, put(fill(16'hff00), 30, 16'd9), 1'b0, 16'd9, 16'd9};
        tbl[8]  = '{4'd5, put(fill(16'hff00), 50, 16'd1), 1'b0, 16'd1, 16'd1};
        tbl[9]  = '{4'd5, put(fill(16'hff00), 60, 16'd7), 1'b1, 16'd7, 16'd7};
        tbl[10] = '{4'd0, put(put(fill(16'hfffb), 3, 16'd9), 50, 16'd100), 1'b1, 16'd9, 16'd100};
        tbl[11] = '{4'd1, put(put(fill(16'h0000), 20, 16'd12), 40, 16'd99), 1'b1, 16'd12, 16'd99};

        i_rst_n = 1'b0; i_en = 1'b1; i_valid = 1'b0; i_clr_err = 1'b0;
        i_length_mode = 4'd0; i_in_flat = '0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("rst_valid", o_valid_max, 0);
        chk("rst_last", o_group_last, 0);
        chk("rst_err", o_err_proto, 0);
        chk("rst_loc", o_loc_max, 16'h8000);
        chk("rst_max64", o_max64_0, 16'h8000);
        chk("rst_max16_3", o_max16_3, 16'h8000);
        chk("rst_mode", o_length_mode, 0);
        chk("rst_flat_zero", o_in_flat == '0, 1);
        chk("ready_follows_en", o_ready, 1);
        i_rst_n = 1'b1;
        tick();

        // Ramp chunk: latency and explicit sub-maxima.
        f = '0;
        for (int k = 0; k < 64; k++) f = put(f, k, 16'(k - 32));
        drive(mk(4'd2, f, 1'b1));
        i_valid = 1'b0;
        for (int t = 1; t < LAT; t++) begin
            tick();
            chk("latency_valid", o_valid_max, (t == LAT - 1) ? 1 : 0);
        end
        chk("ramp_loc", o_loc_max, 16'd31);
        chk("ramp_m16_0", o_max16_0, 16'hffef);
        chk("ramp_m16_1", o_max16_1, 16'hffff);
        chk("ramp_m16_2", o_max16_2, 16'd15);
        chk("ramp_m16_3", o_max16_3, 16'd31);
        chk("ramp_m32_0", o_max32_0, 16'hffff);
        chk("ramp_m32_1", o_max32_1, 16'd31);
        chk("ramp_m64", o_max64_0, 16'd31);
        chk("ramp_last", o_group_last, 1);

        // Table vectors, back to back.
        for (int i = 0; i < 12; i++) begin
            e = mk(tbl[i].mode, tbl[i].flat, tbl[i].last);
            e.loc = tbl[i].loc;
            e.m64 = tbl[i].m64;
            drive(e);
        end
        flush();
        chk("table_err", o_err_proto, 0);

        // Mode change inside a group, clear, illegal mode, clear priority.
        drive(mk(4'd4, fill(16'd1), 1'b0));
        drive(mk(4'd2, fill(16'd2), 1'b1));
        chk("mode_change_err", o_err_proto, 1);
        i_valid = 1'b0; i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        chk("clr_err", o_err_proto, 0);
        drive(mk(4'd14, fill(16'd3), 1'b1));
        chk("illegal_mode_err", o_err_proto, 1);
        i_clr_err = 1'b1;
        drive(mk(4'd15, fill(16'h0004), 1'b1));
        i_clr_err = 1'b0;
        chk("clr_priority", o_err_proto, 0);
        flush();

        // Gap inside a group, then a fresh group.
        drive(mk(4'd6, fill(16'd5), 1'b0));
        drive(mk(4'd6, fill(16'd6), 1'b0));
        i_valid = 1'b0;
        tick();
        chk("gap_err", o_err_proto, 1);
        i_clr_err = 1'b1;
        tick();
        i_clr_err = 1'b0;
        chk("gap_clr", o_err_proto, 0);
        for (int b = 0; b < 5; b++) drive(mk(4'd6, put(fill(16'hfff0), b * 7, 16'(b + 20)), b == 4));
        chk("regroup_err", o_err_proto, 0);
        flush();

        // Stall with beats in flight.
        for (int b = 0; b < 3; b++) drive(mk(4'd2, put(fill(16'hffe0), 60 - b, 16'(b + 40)), 1'b1));
        snap_loc = o_loc_max; snap_flat = o_in_flat; snap_vld = o_valid_max;
        i_en = 1'b0; i_valid = 1'b1; i_in_flat = fill(16'd77); i_length_mode = 4'd5;
        for (int t = 0; t < 5; t++) begin
            tick();
            chk("hold_ready", o_ready, 0);
            chk("hold_loc", o_loc_max, snap_loc);
            chk("hold_valid", o_valid_max, snap_vld);
            chk("hold_flat", o_in_flat === snap_flat, 1);
        end
        i_en = 1'b1;
        flush();
        chk("hold_err", o_err_proto, 0);

        // Reset in the middle of a group.
        drive(mk(4'd5, fill(16'd11), 1'b0));
        drive(mk(4'd5, fill(16'd12), 1'b0));
        i_valid = 1'b0;
        #2 i_rst_n = 1'b0;
        #1;
        chk("mrst_valid", o_valid_max, 0);
        chk("mrst_loc", o_loc_max, 16'h8000);
        chk("mrst_max32_0", o_max32_0, 16'h8000);
        chk("mrst_last", o_group_last, 0);
        chk("mrst_mode", o_length_mode, 0);
        chk("mrst_flat_zero", o_in_flat == '0, 1);
        sbq.delete();
        @(negedge i_clk);
        i_rst_n = 1'b1;
        drive(mk(4'd3, fill(16'd9), 1'b0));
        drive(mk(4'd3, fill(16'd10), 1'b1));
        flush();
        chk("post_rst_err", o_err_proto, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
